jstk_poll_sched: RTL and testbench

Wishbone-configurable scheduler that sequences PmodJSTK SPI transactions and replaces the fixed 5 Hz send/receive divider.
- Issues start requests to the SPI transaction engine at a programmable period, or on a software one-shot.
- Supervises each transaction with a timeout.
- Latches the 40-bit result into packed X/Y/button registers.
- Raises a new-sample interrupt.
- Sits on the Wishbone peripheral bus between the CPU and the joystick SPI engine.

---
 rtl/jstk_pkg.sv | 39 +++
 rtl/jstk_wb_regs.sv | 93 +++++++++
 rtl/jstk_poll_sched.sv | 140 ++++++++++++++
 tb/tb_jstk_poll_sched.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jstk_pkg.sv
// Shared constants for the PmodJSTK poll scheduler: register map, bit indices,
// FSM encoding and the raw-sample to X/Y/button unpacking.
package jstk_pkg;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_PERIOD = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_XY     = 3'd3;
  localparam logic [2:0] REG_BTN    = 3'd4;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_ONESHOT = 1;
  localparam int unsigned CTRL_IRQ_EN  = 2;
  localparam int unsigned CTRL_LED_LO  = 8;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_NEW  = 1;
  localparam int unsigned ST_OVR  = 2;
  localparam int unsigned ST_TMO  = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_REQ  = 2'd2,
    S_BUSY = 2'd3
  } state_t;

  localparam int unsigned X_LO_LSB = 16;
  localparam int unsigned X_HI_LSB = 8;
  localparam int unsigned Y_LO_LSB = 32;
  localparam int unsigned Y_HI_LSB = 24;

  // Byte0 carries Y[7:0], byte2 X[7:0]; the two MSBs of each live in bytes 1 and 3.
  function automatic logic [31:0] pack_xy(input logic [39:0] d);
    return {6'b0, d[Y_HI_LSB +: 2], d[Y_LO_LSB +: 8],
            6'b0, d[X_HI_LSB +: 2], d[X_LO_LSB +: 8]};
  endfunction

endpackage

// File: rtl/jstk_wb_regs.sv
// Wishbone slave for the joystick scheduler: decode, single-wait-state ack,
// CTRL/PERIOD/STATUS storage with write-1-to-clear status and the registered IRQ.
module jstk_wb_regs
  import jstk_pkg::*;
#(
  parameter logic [31:0] DEF_PERIOD = 32'd10_000_000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        busy,
  input  logic [31:0] xy,
  input  logic [2:0]  btn,
  input  logic        sample_evt,
  input  logic        timeout_evt,
  output logic        ctrl_en,
  output logic        ctrl_irq_en,
  output logic [1:0]  ctrl_led,
  output logic        oneshot,
  output logic [31:0] period,
  output logic        irq
);

  logic       ack_ff;
  logic       wr;
  logic [2:0] reg_sel;
  logic [2:0] st_clr;
  logic       st_new, st_ovr, st_tmo;
  logic       unused_adr;

  assign reg_sel    = wb_adr_i[4:2];
  assign wr         = ack_ff & wb_cyc_i & wb_stb_i & wb_we_i & (wb_sel_i == 4'hF);
  assign oneshot    = wr & (reg_sel == REG_CTRL) & wb_dat_i[CTRL_ONESHOT];
  assign st_clr     = (wr && reg_sel == REG_STATUS) ? wb_dat_i[ST_TMO:ST_NEW] : '0;
  assign wb_ack_o   = ack_ff;
  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_ff      <= 1'b0;
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_led    <= '0;
      period      <= DEF_PERIOD;
      st_new      <= 1'b0;
      st_ovr      <= 1'b0;
      st_tmo      <= 1'b0;
      irq         <= 1'b0;
    end else begin
      ack_ff <= ~ack_ff & wb_stb_i & wb_cyc_i;
      if (wr && reg_sel == REG_CTRL) begin
        ctrl_en     <= wb_dat_i[CTRL_EN];
        ctrl_irq_en <= wb_dat_i[CTRL_IRQ_EN];
        ctrl_led    <= wb_dat_i[CTRL_LED_LO +: 2];
      end
      if (wr && reg_sel == REG_PERIOD) period <= wb_dat_i;
      // A new sample always wins over a same-cycle clear.
      st_new <= sample_evt | (st_new & ~st_clr[0]);
      st_ovr <= (sample_evt & st_new) | (st_ovr & ~st_clr[1]);
      st_tmo <= timeout_evt | (st_tmo & ~st_clr[2]);
      irq    <= ctrl_irq_en & (st_new | st_tmo);
    end
  end

  always_comb begin
    wb_dat_o = '0;
    case (reg_sel)
      REG_CTRL: begin
        wb_dat_o[CTRL_EN]            = ctrl_en;
        wb_dat_o[CTRL_IRQ_EN]        = ctrl_irq_en;
        wb_dat_o[CTRL_LED_LO +: 2]   = ctrl_led;
      end
      REG_PERIOD: wb_dat_o = period;
      REG_STATUS: begin
        wb_dat_o[ST_BUSY] = busy;
        wb_dat_o[ST_NEW]  = st_new;
        wb_dat_o[ST_OVR]  = st_ovr;
        wb_dat_o[ST_TMO]  = st_tmo;
      end
      REG_XY:  wb_dat_o = xy;
      REG_BTN: wb_dat_o[2:0] = btn;
      default: wb_dat_o = '0;
    endcase
  end

endmodule

// File: rtl/jstk_poll_sched.sv
// PmodJSTK poll scheduler: periodic/one-shot start requests to the SPI engine,
// per-transaction timeout and capture of the 40-bit sample into X/Y/button registers.
module jstk_poll_sched
  import jstk_pkg::*;
#(
  parameter logic [31:0] DEF_PERIOD = 32'd10_000_000,
  parameter logic [31:0] MIN_PERIOD = 32'd2_000,
  parameter logic [19:0] TIMEOUT    = 20'd200_000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        start_o,
  output logic [1:0]  led_o,
  input  logic        done_i,
  input  logic [39:0] data_i,
  output logic        irq_o
);

  state_t      state, state_nxt;
  logic [31:0] per_cnt, per_nxt;
  logic [19:0] tmo_cnt, tmo_nxt;
  logic [31:0] period, eff_period;
  logic [31:0] xy_q;
  logic [2:0]  btn_q;
  logic        ctrl_en, ctrl_irq_en, oneshot;
  logic [1:0]  ctrl_led;
  logic        sample_evt, timeout_evt, leave;
  logic        unused_data;

  assign wb_err_o    = 1'b0;
  assign start_o     = (state == S_REQ);
  assign eff_period  = (period < MIN_PERIOD) ? MIN_PERIOD : period;
  assign unused_data = ^{data_i[31:26], data_i[15:10], data_i[7:3], ctrl_irq_en};

  jstk_wb_regs #(.DEF_PERIOD(DEF_PERIOD)) u_regs (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_i    (wb_rst_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_stb_i    (wb_stb_i),
    .wb_we_i     (wb_we_i),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_sel_i    (wb_sel_i),
    .wb_dat_o    (wb_dat_o),
    .wb_ack_o    (wb_ack_o),
    .busy        (state == S_BUSY),
    .xy          (xy_q),
    .btn         (btn_q),
    .sample_evt  (sample_evt),
    .timeout_evt (timeout_evt),
    .ctrl_en     (ctrl_en),
    .ctrl_irq_en (ctrl_irq_en),
    .ctrl_led    (ctrl_led),
    .oneshot     (oneshot),
    .period      (period),
    .irq         (irq_o)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= S_IDLE;
      per_cnt <= '0;
      tmo_cnt <= '0;
      led_o   <= '0;
      xy_q    <= '0;
      btn_q   <= '0;
    end else begin
      state   <= state_nxt;
      per_cnt <= per_nxt;
      tmo_cnt <= tmo_nxt;
      if (state == S_REQ) led_o <= ctrl_led;
      if (sample_evt) begin
        xy_q  <= pack_xy(data_i);
        btn_q <= data_i[2:0];
      end
    end
  end

  // The period counter is loaded at each start and keeps running through BUSY so
  // start-to-start spacing equals the period; it is reloaded only if it expired.
  always_comb begin
    state_nxt   = state;
    per_nxt     = per_cnt;
    tmo_nxt     = tmo_cnt;
    sample_evt  = 1'b0;
    timeout_evt = 1'b0;
    leave       = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (oneshot) begin
          state_nxt = S_REQ;
        end else if (ctrl_en) begin
          per_nxt   = eff_period;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        per_nxt = per_cnt - 32'd1;
        if (oneshot)               state_nxt = S_REQ;
        else if (!ctrl_en)         state_nxt = S_IDLE;
        else if (per_cnt <= 32'd1) state_nxt = S_REQ;
      end
      S_REQ: begin
        per_nxt   = eff_period - 32'd1;
        tmo_nxt   = '0;
        state_nxt = S_BUSY;
      end
      S_BUSY: begin
        tmo_nxt = tmo_cnt + 20'd1;
        per_nxt = (per_cnt > 32'd1) ? per_cnt - 32'd1 : per_cnt;
        if (done_i) begin
          sample_evt = 1'b1;
          leave      = 1'b1;
        end else if (tmo_cnt == TIMEOUT - 20'd1) begin
          timeout_evt = 1'b1;
          leave       = 1'b1;
        end
        if (leave) begin
          if (ctrl_en) begin
            state_nxt = S_WAIT;
            if (per_cnt <= 32'd1) per_nxt = eff_period;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_jstk_poll_sched.sv
// Scoreboard bench for jstk_poll_sched: bus reads and start_o spacing are queued
// as expectations and checked by monitors when the DUT presents them.
module tb_jstk_poll_sched;

  localparam logic [19:0] TMO = 20'd4000;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0, wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, start_o, irq_o;
  logic [1:0]  led_o;
  logic        done_i;
  logic [39:0] data_i;

  int          checks = 0, failures = 0;
  int          cyc_cnt = 0, start_cnt = 0, last_start_cyc = 0;
  logic [31:0] rd_exp[$];
  string       rd_name[$];
  int          gap_exp[$];

  logic        eng_respond = 1'b1;
  int          eng_delay = 800;
  logic [39:0] eng_data = '0, stray_data = '0;
  int          stray_req = 0, stray_ack = 0;

  jstk_poll_sched #(.TIMEOUT(TMO)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .start_o(start_o),
    .led_o(led_o), .done_i(done_i), .data_i(data_i), .irq_o(irq_o)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Read monitor: pops the oldest queued expectation on every read acknowledge.
  initial forever begin
    @(negedge wb_clk_i);
    if (wb_ack_o && !wb_we_i) begin
      if (rd_exp.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected: read ack with no queued expectation, data 0x%08h", wb_dat_o);
      end else begin
        check(rd_name.pop_front(), wb_dat_o, rd_exp.pop_front());
      end
    end
  end

  // start_o monitor: counts starts and checks queued start-to-start spacings.
  initial forever begin
    @(negedge wb_clk_i);
    if (start_o) begin
      start_cnt++;
      if (gap_exp.size() > 0) check("start_gap", 32'(cyc_cnt - last_start_cyc), 32'(gap_exp.pop_front()));
      last_start_cyc = cyc_cnt;
    end
  end

  // SPI engine model.
  initial begin
    done_i = 1'b0;
    data_i = '0;
    forever begin
      @(negedge wb_clk_i);
      if (start_o && eng_respond) begin
        repeat (eng_delay) @(posedge wb_clk_i);
        #1 data_i = eng_data; done_i = 1'b1;
        @(posedge wb_clk_i);
        #1 done_i = 1'b0;
      end else if (stray_req != stray_ack) begin
        stray_ack++;
        @(posedge wb_clk_i);
        #1 data_i = stray_data; done_i = 1'b1;
        @(posedge wb_clk_i);
        #1 done_i = 1'b0;
      end
    end
  end

  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    int n = 0;
    @(posedge wb_clk_i);
    #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = 4'hF;
    do begin
      @(negedge wb_clk_i);
      n++;
    end while (!wb_ack_o && n < 8);
    if (!wb_ack_o) begin
      checks++; failures++;
      $display("FAIL wb_ack_timeout: adr 0x%08h got ack 0 expected 1", adr);
    end
    @(posedge wb_clk_i);
    #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = '0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat);
    wb_xfer(1'b1, adr, dat);
  endtask

  task automatic wb_read_exp(input string name, input logic [31:0] adr, input logic [31:0] exp);
    rd_exp.push_back(exp);
    rd_name.push_back(name);
    wb_xfer(1'b0, adr, '0);
  endtask

  task automatic wait_start(input string tag, input int bound);
    int s = start_cnt;
    int n = 0;
    while (start_cnt == s && n < bound) begin
      @(negedge wb_clk_i);
      n++;
    end
    #1;
    checks++;
    if (start_cnt == s) begin
      failures++;
      $display("FAIL %s: got no start_o within %0d cycles, expected one", tag, bound);
    end
  endtask

  initial begin
    int snap, n, gap;

    // Reset state
    repeat (4) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("reset_outputs", {27'b0, start_o, led_o, irq_o, wb_ack_o, wb_err_o}, '0);
    wb_read_exp("rst_ctrl",   32'h00, 32'h0);
    wb_read_exp("rst_period", 32'h04, 32'h0098_9680);
    wb_read_exp("rst_status", 32'h08, 32'h0);
    wb_read_exp("rst_xy",     32'h0C, 32'h0);
    wb_read_exp("rst_btn",    32'h10, 32'h0);
    wb_read_exp("unmapped",   32'h1C, 32'h0);
    check("rst_no_start", start_cnt, 0);

    // Periodic polling at 5000 cycles
    eng_data = 40'hA5_00_3C_01_05;
    wb_write(32'h04, 32'd5000);
    wb_write(32'h00, 32'h1);
    wait_start("first_periodic_start", 6000);
    gap_exp.push_back(5000);
    gap_exp.push_back(5000);
    wait_start("periodic_start2", 6000);
    wait_start("periodic_start3", 6000);
    repeat (900) @(posedge wb_clk_i);
    wb_read_exp("per_xy",     32'h0C, 32'h00A5_013C);
    wb_read_exp("per_btn",    32'h10, 32'h5);
    wb_read_exp("per_status", 32'h08, 32'h6);
    wb_write(32'h08, 32'h6);
    wb_read_exp("per_status_clr", 32'h08, 32'h0);

    // Short period clamps to MIN_PERIOD from the next reload
    wb_write(32'h04, 32'd100);
    wb_read_exp("period_raw", 32'h04, 32'd100);
    wait_start("clamp_start1", 6000);
    gap_exp.push_back(2000);
    gap_exp.push_back(2000);
    wait_start("clamp_start2", 3000);
    wait_start("clamp_start3", 3000);
    wb_write(32'h00, 32'h0);
    snap = start_cnt;
    repeat (3000) @(posedge wb_clk_i);
    check("en_off_no_start", start_cnt, snap);
    wb_write(32'h08, 32'hE);
    wb_read_exp("clamp_status_clr", 32'h08, 32'h0);

    // One-shot, stray done, one-shot ignored while busy, overrun
    eng_data = 40'h12_03_56_02_07;
    snap = start_cnt;
    wb_write(32'h00, 32'h2);
    repeat (1000) @(posedge wb_clk_i);
    check("oneshot1_count", start_cnt, snap + 1);
    wb_read_exp("os1_status", 32'h08, 32'h2);
    wb_read_exp("os1_xy",     32'h0C, 32'h0312_0256);
    wb_read_exp("os1_btn",    32'h10, 32'h7);
    check("irq_gated", {31'b0, irq_o}, 32'h0);
    stray_data = 40'hFF_FF_FF_FF_FF;
    stray_req++;
    repeat (10) @(posedge wb_clk_i);
    wb_read_exp("stray_xy", 32'h0C, 32'h0312_0256);
    wb_write(32'h00, 32'h302);
    repeat (50) @(posedge wb_clk_i);
    #1 check("led_latched", {30'b0, led_o}, 32'h3);
    wb_read_exp("os2_busy_status", 32'h08, 32'h3);
    wb_write(32'h00, 32'h302);
    repeat (1000) @(posedge wb_clk_i);
    check("oneshot2_count", start_cnt, snap + 2);
    wb_read_exp("os2_status", 32'h08, 32'h6);
    wb_read_exp("os2_ctrl",   32'h00, 32'h300);
    wb_write(32'h08, 32'hE);

    // Timeout with IRQ enabled, then W1C of TMO
    eng_respond = 1'b0;
    wb_write(32'h00, 32'h6);
    n = 0;
    while (!irq_o && n < int'(TMO) + 100) begin
      @(negedge wb_clk_i);
      n++;
    end
    gap = cyc_cnt - last_start_cyc;
    checks++;
    if (!irq_o || gap < int'(TMO) || gap > int'(TMO) + 2) begin
      failures++;
      $display("FAIL tmo_irq_delay: got irq=%0b after %0d cycles, expected 1 after %0d..%0d",
               irq_o, gap, TMO, int'(TMO) + 2);
    end
    wb_read_exp("tmo_status", 32'h08, 32'h8);
    wb_read_exp("tmo_xy",     32'h0C, 32'h0312_0256);
    wb_write(32'h08, 32'h8);
    repeat (2) @(negedge wb_clk_i);
    check("irq_cleared", {31'b0, irq_o}, 32'h0);

    // Reset during BUSY; late done must be ignored
    eng_respond = 1'b1;
    eng_data = 40'h11_22_33_44_55;
    wb_write(32'h00, 32'h303);
    wait_start("pre_reset_start", 100);
    repeat (100) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("midreset_outputs", {27'b0, start_o, led_o, irq_o, wb_ack_o, wb_err_o}, '0);
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    snap = start_cnt;
    repeat (1000) @(posedge wb_clk_i);
    check("post_reset_no_start", start_cnt, snap);
    wb_read_exp("post_rst_xy",     32'h0C, 32'h0);
    wb_read_exp("post_rst_btn",    32'h10, 32'h0);
    wb_read_exp("post_rst_status", 32'h08, 32'h0);
    wb_read_exp("post_rst_ctrl",   32'h00, 32'h0);
    wb_read_exp("post_rst_period", 32'h04, 32'h0098_9680);

    repeat (4) @(posedge wb_clk_i);
    check("rd_queue_drained", rd_exp.size(), 0);
    check("gap_queue_drained", gap_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
